// File: rtl/bcd_serial_subtractor_if.sv
// Handshake and operand/result bundle for the digit-serial BCD subtractor.
// The master drives the operands and start; the slave returns status and the result.
interface bcd_serial_subtractor_if #(
   parameter int DIGITS = 4
);
   logic                  start;
   logic [4*DIGITS-1:0]   a;
   logic [4*DIGITS-1:0]   b;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   diff;
   logic                  neg;
   logic                  invalid;

   modport master (
      output start, a, b,
      input  busy, done, diff, neg, invalid
   );

   modport slave (
      input  start, a, b,
      output busy, done, diff, neg, invalid
   );
endinterface

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial |A - B| on packed BCD, one digit per clock. A borrow out of the
// top digit means the result is a ten's complement, so a second pass negates it.
module bcd_serial_subtractor #(
   parameter int DIGITS = 4
) (
   input logic                    clk,
   input logic                    rst_n,
   bcd_serial_subtractor_if.slave bus
);
   localparam int W  = 4 * DIGITS;
   localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t          state_reg, state_next;
   logic [W-1:0]    a_sh_reg, a_sh_next;
   logic [W-1:0]    b_sh_reg, b_sh_next;
   logic [W-1:0]    r_sh_reg, r_sh_next;
   logic [W-1:0]    diff_reg, diff_next;
   logic [CW-1:0]   cnt_reg, cnt_next;
   logic            borrow_reg, borrow_next;
   logic            inv_reg, inv_next;
   logic            busy_reg, busy_next;
   logic            done_reg, done_next;
   logic            neg_reg, neg_next;
   logic            invalid_reg, invalid_next;

   logic [2*DIGITS-1:0] nib_bad;
   logic                any_bad;
   logic [3:0]          x_dig, y_dig, res_dig;
   logic [4:0]          t;
   logic                t_neg;

   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_chk
         assign nib_bad[gi]        = bus.a[4*gi +: 4] > 4'd9;
         assign nib_bad[DIGITS+gi] = bus.b[4*gi +: 4] > 4'd9;
      end
   endgenerate

   assign any_bad = |nib_bad;

   // Shared digit slice: RUN computes a_i - b_i, FIX computes 0 - r_i.
   always_comb begin
      x_dig   = (state_reg == RUN) ? a_sh_reg[3:0] : 4'd0;
      y_dig   = (state_reg == RUN) ? b_sh_reg[3:0] : r_sh_reg[3:0];
      t       = {1'b0, x_dig} - {1'b0, y_dig} - {4'd0, borrow_reg};
      t_neg   = t[4];
      res_dig = t_neg ? (t[3:0] + 4'd10) : t[3:0];
   end

   always_comb begin
      state_next   = state_reg;
      a_sh_next    = a_sh_reg;
      b_sh_next    = b_sh_reg;
      r_sh_next    = r_sh_reg;
      cnt_next     = cnt_reg;
      borrow_next  = borrow_reg;
      inv_next     = inv_reg;
      diff_next    = diff_reg;
      neg_next     = neg_reg;
      invalid_next = invalid_reg;

      case (state_reg)
         IDLE: begin
            if (bus.start) begin
               a_sh_next   = bus.a;
               b_sh_next   = bus.b;
               r_sh_next   = '0;
               cnt_next    = '0;
               borrow_next = 1'b0;
               inv_next    = any_bad;
               state_next  = RUN;
            end
         end
         RUN: begin
            if (inv_reg) begin
               state_next = DONE;
            end else begin
               a_sh_next          = a_sh_reg >> 4;
               b_sh_next          = b_sh_reg >> 4;
               r_sh_next          = r_sh_reg >> 4;
               r_sh_next[W-1 -: 4] = res_dig;
               borrow_next        = t_neg;
               cnt_next           = cnt_reg + 1'b1;
               if (cnt_reg == LAST) begin
                  cnt_next = '0;
                  if (t_neg) begin
                     borrow_next = 1'b0;
                     state_next  = FIX;
                  end else begin
                     state_next = DONE;
                  end
               end
            end
         end
         FIX: begin
            r_sh_next          = r_sh_reg >> 4;
            r_sh_next[W-1 -: 4] = res_dig;
            borrow_next        = t_neg;
            cnt_next           = cnt_reg + 1'b1;
            if (cnt_reg == LAST) begin
               cnt_next   = '0;
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // Results are published on entry to DONE so they are valid alongside done.
      if (state_next == DONE) begin
         if (inv_reg) begin
            diff_next    = '0;
            neg_next     = 1'b0;
            invalid_next = 1'b1;
         end else begin
            diff_next    = r_sh_next;
            neg_next     = (state_reg == FIX);
            invalid_next = 1'b0;
         end
      end

      done_next = (state_next == DONE);
      busy_next = (state_next == FIX) || ((state_next == RUN) && !inv_next);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         a_sh_reg    <= '0;
         b_sh_reg    <= '0;
         r_sh_reg    <= '0;
         cnt_reg     <= '0;
         borrow_reg  <= 1'b0;
         inv_reg     <= 1'b0;
         diff_reg    <= '0;
         neg_reg     <= 1'b0;
         invalid_reg <= 1'b0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         a_sh_reg    <= a_sh_next;
         b_sh_reg    <= b_sh_next;
         r_sh_reg    <= r_sh_next;
         cnt_reg     <= cnt_next;
         borrow_reg  <= borrow_next;
         inv_reg     <= inv_next;
         diff_reg    <= diff_next;
         neg_reg     <= neg_next;
         invalid_reg <= invalid_next;
         busy_reg    <= busy_next;
         done_reg    <= done_next;
      end
   end

   assign bus.busy    = busy_reg;
   assign bus.done    = done_reg;
   assign bus.diff    = diff_reg;
   assign bus.neg     = neg_reg;
   assign bus.invalid = invalid_reg;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Bench for bcd_serial_subtractor: directed cases then random operands checked
// against a decimal-arithmetic reference model.
module tb_bcd_serial_subtractor;
   localparam int D = 4;
   localparam int W = 4 * D;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   logic [W-1:0] last_diff;
   logic         last_neg;
   logic         last_inv;

   bcd_serial_subtractor_if #(.DIGITS(D)) bus ();

   bcd_serial_subtractor #(.DIGITS(D)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int bcd2int(input logic [W-1:0] v);
      int r;
      r = 0;
      for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
      return r;
   endfunction

   function automatic logic [W-1:0] int2bcd(input int v);
      logic [W-1:0] r;
      int           x;
      r = '0;
      x = v;
      for (int i = 0; i < D; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic bit has_bad(input logic [W-1:0] v);
      bit bad;
      bad = 1'b0;
      for (int i = 0; i < D; i++) if (v[4*i +: 4] > 4'd9) bad = 1'b1;
      return bad;
   endfunction

   // One operation: checks held results, latency, busy length, outputs, pulse width.
   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit noise);
      bit           bad, got;
      int           ai, bi, n, busy_cnt, exp_lat;
      logic [W-1:0] exp_diff;
      logic         exp_neg;
      bad = has_bad(av) || has_bad(bv);
      ai  = bad ? 0 : bcd2int(av);
      bi  = bad ? 0 : bcd2int(bv);
      exp_neg  = !bad && (ai < bi);
      exp_diff = bad ? '0 : int2bcd((ai >= bi) ? ai - bi : bi - ai);
      exp_lat  = bad ? 1 : ((ai >= bi) ? D : 2 * D);

      @(negedge clk);
      bus.a = av;
      bus.b = bv;
      bus.start = 1'b1;
      @(posedge clk);
      got = 1'b0;
      n = 0;
      busy_cnt = 0;
      while (!got && n < 3 * D + 4) begin
         @(negedge clk);
         n++;
         if (n == 1) bus.start = 1'b0;
         if (noise && n == 2) begin
            bus.start = 1'b1;
            bus.a = ~av;
         end
         if (noise && n == 3) bus.start = 1'b0;
         if (bus.busy) busy_cnt++;
         if (bus.done) got = 1'b1;
         else chk("hold_diff", bus.diff, last_diff);
      end
      chk("done_seen", got, 1);
      chk("latency", n - 1, exp_lat);
      chk("busy_cycles", busy_cnt, bad ? 0 : exp_lat);
      chk("diff", bus.diff, exp_diff);
      chk("neg", bus.neg, exp_neg);
      chk("invalid", bus.invalid, bad);
      $display("op a=%h b=%h -> diff=%h neg=%0d invalid=%0d latency=%0d", av, bv,
               bus.diff, bus.neg, bus.invalid, n - 1);
      if (noise) bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("done_width", bus.done, 0);
      last_diff = exp_diff;
      last_neg  = exp_neg;
      last_inv  = bad;
   endtask

   task automatic expect_quiet(input int cycles);
      int dones;
      dones = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      chk("no_extra_done", dones, 0);
   endtask

   function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
      logic [W-1:0] v;
      for (int i = 0; i < D; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
      if (allow_bad && $urandom_range(0, 7) == 0)
         v[4*$urandom_range(0, D - 1) +: 4] = 4'($urandom_range(10, 15));
      return v;
   endfunction

   initial begin
      logic [W-1:0] ra, rb;
      int           dones;
      checks = 0;
      errors = 0;
      last_diff = '0;
      last_neg  = 1'b0;
      last_inv  = 1'b0;
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.a = '0;
      bus.b = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_diff", bus.diff, 0);
      chk("rst_neg", bus.neg, 0);
      chk("rst_invalid", bus.invalid, 0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(16'h5432, 16'h1234, 1'b0);
      run_op(16'h1234, 16'h5432, 1'b0);
      run_op(16'h0000, 16'h0001, 1'b0);
      run_op(16'h9999, 16'h9999, 1'b0);
      run_op(16'h12A4, 16'h0001, 1'b0);
      run_op(16'h0870, 16'h0215, 1'b1);
      expect_quiet(3 * D + 4);
      run_op(16'h1234, 16'h5432, 1'b0);

      // Abort during the negation pass of 0x0100 - 0x0200.
      @(negedge clk);
      bus.a = 16'h0100;
      bus.b = 16'h0200;
      bus.start = 1'b1;
      @(posedge clk);
      repeat (D + 1) @(negedge clk);
      bus.start = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", bus.busy, 0);
      chk("abort_done", bus.done, 0);
      chk("abort_diff", bus.diff, 0);
      chk("abort_neg", bus.neg, 0);
      chk("abort_invalid", bus.invalid, 0);
      dones = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      rst_n = 1'b1;
      repeat (2 * D + 2) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      chk("abort_no_done", dones, 0);
      $display("abort during FIX: dones after reset=%0d", dones);
      last_diff = '0;
      last_neg  = 1'b0;
      last_inv  = 1'b0;
      run_op(16'h0100, 16'h0099, 1'b0);

      for (int k = 0; k < 24; k++) begin
         ra = rand_bcd(1'b1);
         rb = ($urandom_range(0, 7) == 0) ? ra : rand_bcd(1'b1);
         run_op(ra, rb, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
